mux_b_seq: RTL

- Parametrised, registered successor to the datapath operand-B selector.
- Selects one of N source channels (immediate extender, data memory, forwarding paths, ...) and presents it as the ALU B operand.
- Waits for the chosen source to assert valid (data memory may be multi-cycle) and holds the result under a valid/ready handshake.
- Flags bad selects and sources that never respond.

---
 rtl/mux_b_seq_if.sv | 48 ++++
 rtl/mux_b_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_b_seq_if.sv
// mux_b_seq_if: bus bundle for the registered operand-B selector.
//
// Carries the source channels, the request/select inputs and the
// registered-operand handshake between a requester and mux_b_seq.
//   master : requester side (drives sources, select, req, out_ready)
//   slave  : mux_b_seq side (drives operand, status and error flags)
//
// Signal summary:
//   src_data    N_SRC*WIDTH  packed sources, channel k = [k*WIDTH +: WIDTH]
//   src_valid   N_SRC        per-channel data valid
//   sel_B       SEL_W        channel select, sampled when a request is accepted
//   req         1            request to fetch an operand
//   out_ready   1            consumer ready
//   mux_B_out   WIDTH        registered operand
//   out_valid   1            mux_B_out holds a valid operand
//   busy        1            selector is waiting or holding
//   sel_err     1            one-cycle pulse, request with out-of-range select
//   timeout_err 1            one-cycle pulse, wait aborted on timeout
//   wait_cnt    CNT_W        cycles spent in the current wait
interface mux_b_seq_if #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned SEL_W   = $clog2(N_SRC),
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
);
    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_valid;
    logic [SEL_W-1:0]       sel_B;
    logic                   req;
    logic                   out_ready;
    logic [WIDTH-1:0]       mux_B_out;
    logic                   out_valid;
    logic                   busy;
    logic                   sel_err;
    logic                   timeout_err;
    logic [CNT_W-1:0]       wait_cnt;

    modport master (
        output src_data, src_valid, sel_B, req, out_ready,
        input  mux_B_out, out_valid, busy, sel_err, timeout_err, wait_cnt
    );

    modport slave (
        input  src_data, src_valid, sel_B, req, out_ready,
        output mux_B_out, out_valid, busy, sel_err, timeout_err, wait_cnt
    );
endinterface

// File: rtl/mux_b_seq.sv
// mux_b_seq: registered, parametrised operand-B selector.
//
// Picks one of N_SRC source channels (immediate extender, data memory,
// forwarding paths, ...) and registers it as the ALU B operand. A request
// latches the select; if the chosen source is not yet valid the block waits
// for it (bounded by TIMEOUT cycles) and then holds the operand under a
// valid/ready handshake. Out-of-range selects and non-responding sources
// are reported with one-cycle error pulses.
//
// Ports:
//   clk  in   system clock, all logic on the rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of mux_b_seq_if (sources, select, req, handshake,
//        operand, busy, error pulses, wait counter)
module mux_b_seq #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned SEL_W   = $clog2(N_SRC),
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input logic        clk,
    input logic        rst,
    mux_b_seq_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sel_err_q, sel_err_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Channel picked by the incoming select and by the latched select.
    logic [WIDTH-1:0] new_data, cur_data;
    logic             new_valid, cur_valid;
    logic             sel_bad;
    logic             start;

    // Loop compare instead of a direct index so out-of-range selects read
    // as zero/invalid rather than past the end of the packed vector.
    always_comb begin
        new_data  = '0;
        new_valid = 1'b0;
        cur_data  = '0;
        cur_valid = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (32'(bus.sel_B) == k) begin
                new_data  = bus.src_data[k*WIDTH +: WIDTH];
                new_valid = bus.src_valid[k];
            end
            if (32'(sel_q) == k) begin
                cur_data  = bus.src_data[k*WIDTH +: WIDTH];
                cur_valid = bus.src_valid[k];
            end
        end
    end

    assign sel_bad = (32'(bus.sel_B) >= N_SRC);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        sel_err_d = 1'b0;
        tmo_d     = 1'b0;
        start     = 1'b0;

        unique case (state_q)
            StIdle: begin
                start = bus.req;
            end
            StWait: begin
                // req is deliberately ignored while waiting.
                if (cur_valid) begin
                    data_d  = cur_data;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    // A request in the handshake cycle starts back-to-back.
                    start   = bus.req;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            if (sel_bad) begin
                sel_err_d = 1'b1;
                state_d   = StIdle;
            end else begin
                sel_d = bus.sel_B;
                if (new_valid) begin
                    data_d  = new_data;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.mux_B_out   = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.sel_err     = sel_err_q;
    assign bus.timeout_err = tmo_q;
    assign bus.wait_cnt    = cnt_q;

endmodule
